// File: rtl/matrix_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mem_server
// Brief    : Element store for the matrix operator units with a zero-fill engine.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 9
`endif

module matrix_mem_server #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
    parameter int DEPTH         = 400
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_rd_en,
    input  logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     mem_rd_valid,
    input  logic                     mem_wr_en,
    input  logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_wr_data,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic                     wr_drop,
    output logic                     oob_err
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One bit wider than the address so the DEPTH compare and cptr cannot wrap.
    localparam int c_PTR_W = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_PTR_W-1:0]       r_cptr;
    logic [ELEMENT_WIDTH-1:0] r_mem [DEPTH];

    logic                     w_rd_in_range;
    logic                     w_wr_in_range;
    logic                     w_op_wr;
    logic                     w_clr_wr;
    logic                     w_we;
    logic [c_IDX_W-1:0]       w_waddr;
    logic [ELEMENT_WIDTH-1:0] w_wdata;
    logic [c_IDX_W-1:0]       w_rd_idx;

    assign w_rd_in_range = {1'b0, mem_rd_addr} < c_DEPTH;
    assign w_wr_in_range = {1'b0, mem_wr_addr} < c_DEPTH;
    assign w_op_wr       = mem_wr_en && w_wr_in_range && (r_state == S_IDLE);
    assign w_clr_wr      = (r_state == S_CLEAR);
    assign w_we          = w_op_wr || w_clr_wr;
    assign w_rd_idx      = mem_rd_addr[c_IDX_W-1:0];

    // The clear engine owns the single write port while it runs.
    always_comb begin
        w_waddr = mem_wr_addr[c_IDX_W-1:0];
        w_wdata = mem_wr_data;
        if (w_clr_wr) begin
            w_waddr = r_cptr[c_IDX_W-1:0];
            w_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cptr       <= '0;
            mem_rd_data  <= '0;
            mem_rd_valid <= 1'b0;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
            wr_drop      <= 1'b0;
            oob_err      <= 1'b0;
        end else begin
            mem_rd_valid <= mem_rd_en;
            if (mem_rd_en) begin
                if (!w_rd_in_range) begin
                    mem_rd_data <= '0;
                end else if (w_we && (w_waddr == w_rd_idx)) begin
                    mem_rd_data <= w_wdata;
                end else begin
                    mem_rd_data <= r_mem[w_rd_idx];
                end
            end

            wr_drop <= mem_wr_en && w_wr_in_range && (r_state != S_IDLE);
            if ((mem_rd_en && !w_rd_in_range) || (mem_wr_en && !w_wr_in_range)) begin
                oob_err <= 1'b1;
            end

            clear_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_cptr     <= '0;
                        r_state    <= S_CLEAR;
                        clear_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_cptr == c_LAST) begin
                        r_state    <= S_DONE;
                        clear_done <= 1'b1;
                    end else begin
                        r_cptr <= r_cptr + c_PTR_W'(1);
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    clear_busy <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mem_server
// Brief    : Scoreboard bench for matrix_mem_server with a 16-word store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mem_server;

    localparam int c_EW    = 8;
    localparam int c_AW    = 9;
    localparam int c_DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_rd_en = 1'b0;
    logic [c_AW-1:0] mem_rd_addr = '0;
    logic [c_EW-1:0] mem_rd_data;
    logic            mem_rd_valid;
    logic            mem_wr_en = 1'b0;
    logic [c_AW-1:0] mem_wr_addr = '0;
    logic [c_EW-1:0] mem_wr_data = '0;
    logic            clear_start = 1'b0;
    logic            clear_busy;
    logic            clear_done;
    logic            wr_drop;
    logic            oob_err;

    matrix_mem_server #(
        .ELEMENT_WIDTH (c_EW),
        .ADDR_WIDTH    (c_AW),
        .DEPTH         (c_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .wr_drop      (wr_drop),
        .oob_err      (oob_err)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [c_EW-1:0] model [c_DEPTH];
    logic [c_EW-1:0] exp_q [$];
    bit              clearing = 1'b0;
    int              cyc = 0;
    int              busy_cnt = 0;
    int              done_cnt = 0;
    int              done_cyc = 0;
    int              start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and clear-activity monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (clear_busy) busy_cnt++;
        if (clear_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("sb_rd_data", {24'd0, mem_rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive(input logic re, input logic [c_AW-1:0] ra, input logic we,
                         input logic [c_AW-1:0] wa, input logic [c_EW-1:0] wd, input logic cs);
        mem_rd_en   = re;
        mem_rd_addr = ra;
        mem_wr_en   = we;
        mem_wr_addr = wa;
        mem_wr_data = wd;
        clear_start = cs;
        if (we && !clearing && (wa < c_DEPTH)) model[wa[3:0]] = wd;
        if (re) exp_q.push_back((ra < c_DEPTH) ? model[ra[3:0]] : '0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic run_clear_to_end(input string tag);
        for (int i = 0; i < 60 && !(done_cnt > 0 && !clear_busy); i++) idle();
        check({tag, "_busy_cycles"}, busy_cnt, 17);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc - start_cyc, c_DEPTH);
        clearing = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_rd_data", {24'd0, mem_rd_data}, 32'd0);
        check("rst_rd_valid", mem_rd_valid, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_done", clear_done, 0);
        check("rst_wr_drop", wr_drop, 0);
        check("rst_oob", oob_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < c_DEPTH; i++) drive(1'b0, '0, 1'b1, c_AW'(i), c_EW'(i * 3 + 1), 1'b0);

        // Basic write then read, data must hold while idle.
        drive(1'b0, '0, 1'b1, 9'd7, 8'h5A, 1'b0);
        drive(1'b1, 9'd7, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("rd_hold", {24'd0, mem_rd_data}, 32'h5A);
        end

        // Write-first collision.
        drive(1'b0, '0, 1'b1, 9'd12, 8'h11, 1'b0);
        drive(1'b1, 9'd12, 1'b1, 9'd12, 8'h22, 1'b0);
        idle();

        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(1)), c_AW'($urandom_range(15)),
                  1'($urandom_range(1)), c_AW'($urandom_range(15)),
                  c_EW'($urandom_range(255)), 1'b0);
        end
        idle();

        // Clear over a full store, with a dropped write and a redundant start.
        for (int i = 0; i < c_DEPTH; i++) drive(1'b0, '0, 1'b1, c_AW'(i), 8'hFF, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        start_cyc = cyc;
        clearing  = 1'b1;
        drive(1'b0, '0, 1'b1, 9'd3, 8'h33, 1'b0);
        check("clr_wr_drop", wr_drop, 1);
        idle();
        check("clr_wr_drop_pulse", wr_drop, 0);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        run_clear_to_end("clr1");
        for (int i = 0; i < c_DEPTH; i++) drive(1'b1, c_AW'(i), 1'b0, '0, '0, 1'b0);
        idle();

        // Out-of-range accesses.
        check("oob_before", oob_err, 0);
        drive(1'b0, '0, 1'b1, 9'd4, 8'h44, 1'b0);
        drive(1'b1, 9'd20, 1'b0, '0, '0, 1'b0);
        check("oob_rd_flag", oob_err, 1);
        drive(1'b0, '0, 1'b1, 9'd20, 8'h77, 1'b0);
        check("oob_wr_no_drop", wr_drop, 0);
        drive(1'b1, 9'd4, 1'b0, '0, '0, 1'b0);
        repeat (4) idle();
        check("oob_sticky", oob_err, 1);

        // Reset in the middle of a clear.
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        clearing = 1'b1;
        repeat (5) idle();
        done_cnt = 0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", clear_busy, 0);
        check("mid_rst_oob", oob_err, 0);
        check("mid_rst_rd_data", {24'd0, mem_rd_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle();
        check("mid_rst_no_done", done_cnt, 0);
        busy_cnt = 0;
        done_cnt = 0;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        start_cyc = cyc;
        run_clear_to_end("clr2");
        for (int i = 0; i < c_DEPTH; i += 5) drive(1'b1, c_AW'(i), 1'b0, '0, '0, 1'b0);
        repeat (2) idle();

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_mem_server.md
# matrix_mem_server

Responder side of the matrix operator memory interface. Holds the element store and answers the `mem_rd_*` / `mem_wr_*` requests that operator units such as the scalar-multiply, add and transpose engines issue. Sits between the op-unit mux and the storage array. Also owns a clear engine that zeroes the store before matrices are loaded.

## Interface

**Parameters**
- `ELEMENT_WIDTH`, default `` `ELEMENT_WIDTH `` (8): bits per matrix element.
- `ADDR_WIDTH`, default `` `BRAM_ADDR_WIDTH `` (9): request address width.
- `DEPTH`, default 400: number of implemented words, with 1 ≤ `DEPTH` ≤ 2^`ADDR_WIDTH`. Valid addresses are 0..`DEPTH`-1.

**Ports**
- One clock and one reset. Reset is asynchronous and active-high.
- `clk` in, 1: system clock. All logic is rising-edge.
- `rst` in, 1: asynchronous, active-high reset.
- `mem_rd_en` in, 1: read request, sampled each edge.
- `mem_rd_addr` in, `ADDR_WIDTH`: read address.
- `mem_rd_data` out, `ELEMENT_WIDTH`: registered read data.
- `mem_rd_valid` out, 1: one-cycle pulse marking new `mem_rd_data`.
- `mem_wr_en` in, 1: write request.
- `mem_wr_addr` in, `ADDR_WIDTH`: write address.
- `mem_wr_data` in, `ELEMENT_WIDTH`: write data.
- `clear_start` in, 1: request a zero-fill of the whole store.
- `clear_busy` out, 1: high while the clear engine owns the write port.
- `clear_done` out, 1: one-cycle pulse when the zero-fill completes.
- `wr_drop` out, 1: one-cycle pulse when an operator write was discarded.
- `oob_err` out, 1: sticky flag, set by any request with address ≥ `DEPTH`.

## Operation

- **Storage:** `DEPTH` × `ELEMENT_WIDTH` array, synchronous write, registered read. Array contents are not reset.
- **Read:**
  - On an edge with `mem_rd_en`=1, `mem_rd_data` loads the word at `mem_rd_addr` and `mem_rd_valid` is set for one cycle.
  - `mem_rd_data` holds its value until the next accepted read. Operators sample it any later cycle.
  - An out-of-range read returns 0, asserts `mem_rd_valid` and sets `oob_err`.
- **Write:**
  - On an edge with `mem_wr_en`=1 in `S_IDLE` and an in-range address, the word is written.
  - An out-of-range write is discarded and sets `oob_err`. It does not pulse `wr_drop`.
- **Read/write collision:** a read and a write to the same address on the same edge is write-first. `mem_rd_data` returns the new `mem_wr_data`.
- **Clear FSM:**
  - `S_IDLE`: `clear_busy`=0. If `clear_start`=1, clear the pointer `cptr` to 0 and go to `S_CLEAR`.
  - `S_CLEAR`: `clear_busy`=1. Each cycle write 0 at `cptr`, then `cptr`+1. After writing `DEPTH`-1, go to `S_DONE`.
  - `S_DONE`: pulse `clear_done` for one cycle, then go to `S_IDLE`. Returning to `S_IDLE` does not depend on `clear_start`.
- **During `S_CLEAR`/`S_DONE`:**
  - Operator writes are discarded and `wr_drop` pulses.
  - Reads are still served. A read of the address being cleared that cycle returns 0, following the write-first rule.
- `clear_start` is ignored outside `S_IDLE`.
- `oob_err` clears only on `rst`.

## Timing

- **Reset values:** `mem_rd_data`=0, `mem_rd_valid`=0, `clear_busy`=0, `clear_done`=0, `wr_drop`=0, `oob_err`=0. State `S_IDLE`, `cptr`=0.
- **Read latency:** 1 edge. A request sampled at edge k gives data and `mem_rd_valid` in the cycle after edge k. Back-to-back reads sustain one per cycle.
- **Write visibility:** a write at edge k is visible to a read sampled at edge k (write-first) or later.
- **Clear duration:** `clear_start` sampled at edge k. `clear_busy` is high from after edge k until after edge k+`DEPTH`+1. `clear_done` is high in the cycle after edge k+`DEPTH`.
- **Reset mid-clear:** return to `S_IDLE` immediately. The partially cleared contents are unspecified, and no `clear_done` pulse occurs.
- **`cptr` width:** wide enough that the terminal compare against `DEPTH`-1 cannot wrap for `DEPTH` = 2^`ADDR_WIDTH`.

## Test plan

- **Basic write/read:** write 0x5A to addr 7. Read addr 7 on the next edge. Expect `mem_rd_data`=0x5A with `mem_rd_valid` one cycle later. `mem_rd_data` holds 0x5A for the next 3 idle cycles.
- **Write-first collision:** preload addr 12 = 0x11. On the same edge, write 0x22 to addr 12 and read addr 12. Expect `mem_rd_data`=0x22.
- **Clear:** `DEPTH`=16. Preload every word with 0xFF, pulse `clear_start`. Expect `clear_busy` high for 17 cycles and `clear_done` in exactly one cycle. All 16 reads then return 0.
- **Write during clear:** write 0x33 to addr 3 while `clear_busy`. Expect `wr_drop` pulse and addr 3 reads 0 after the clear. A second `clear_start` mid-clear has no effect on duration.
- **Out-of-range:** `DEPTH`=16. Read addr 20 and expect 0 with valid and `oob_err`=1. Write addr 20 and confirm no aliasing into addr 4. `oob_err` stays high until `rst`.
- **Reset mid-clear:** assert `rst` 5 cycles into a clear. Expect all outputs at reset values asynchronously, no `clear_done`, and a new clear completes normally.
